// File: rtl/uart_tx_t.sv
// uart_tx_t: buffered 8N1 UART transmitter, a FIFO feeding a bit-serial shifter.
// TXD and busy are registered one cycle behind the state, so nothing from the inputs reaches the pin combinationally.
module uart_tx_t #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       TXD
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, wrap, txd_q, busy_q;
    // A write while full is dropped even if the shifter pops in the same cycle.
    assign full    = count_q == CNTW'(FIFO_DEPTH);
    assign empty   = count_q == '0;
    assign push    = wr_en && !full;
    assign pop     = state_q == IDLE && !empty;
    assign wrap    = baud_q == CW'(CPB - 1);
    assign count_d = count_q + CNTW'(push) - CNTW'(pop);
    assign TXD     = txd_q;
    assign busy    = busy_q;
    always_ff @(posedge clk)
        if (push) mem_q[wptr_q] <= data_in;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= push ? wptr_q + AW'(1) : wptr_q;
            rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            txd_q  <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
            busy_q <= state_q != IDLE;
            baud_q <= (state_q == IDLE || wrap) ? '0 : baud_q + CW'(1);
            case (state_q)
                IDLE: if (!empty) begin
                    shift_q <= mem_q[rptr_q];
                    state_q <= START;
                end
                START: if (wrap) begin
                    bit_q   <= '0;
                    state_q <= DATA;
                end
                DATA: if (wrap) begin
                    shift_q <= shift_q >> 1;
                    bit_q   <= bit_q + 3'd1;
                    if (bit_q == 3'd7) state_q <= STOP;
                end
                STOP: if (wrap) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_t.sv
// tb_uart_tx_t: directed bench for uart_tx_t at 10 clocks per bit.
// Line, busy, empty and full are captured per cycle, then checked against hand-derived timing.
module tb_uart_tx_t;
    logic       clk = 0;
    logic       rst = 1;
    logic [7:0] data_in = '0;
    logic       wr_en = 0;
    logic       full, empty, busy, TXD;
    int         n_tests = 0;
    int         n_fail = 0;
    localparam int N = 4200;
    logic       line_q  [N];
    logic       busy_l  [N];
    logic       empty_l [N];
    logic       full_l  [N];
    logic [7:0] wb [64];
    logic [7:0] rx_q [$];
    int         fe;
    uart_tx_t #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en),
        .full(full), .empty(empty), .busy(busy), .TXD(TXD)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1;
        wr_en = 0;
        repeat (3) tick();
        rst = 0;
    endtask
    // Cycle t is sampled 1 time unit after its opening edge; writes driven at t land on the edge closing t.
    task automatic run(input int n, input int nb, input bit gated);
        int k;
        k = 0;
        for (int t = 0; t < n; t++) begin
            line_q[t]  = TXD;
            busy_l[t]  = busy;
            empty_l[t] = empty;
            full_l[t]  = full;
            if (k < nb && (!gated || !full)) begin
                wr_en = 1;
                data_in = wb[k];
                k++;
            end else wr_en = 0;
            tick();
        end
        wr_en = 0;
    endtask
    task automatic decode(input int n);
        int i;
        logic [7:0] b;
        i = 0;
        fe = 0;
        rx_q.delete();
        while (i + 100 <= n) begin
            if (line_q[i] == 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = line_q[i + 15 + 10 * j];
                if (line_q[i + 5] !== 1'b0 || line_q[i + 95] !== 1'b1) fe++;
                rx_q.push_back(b);
                i += 100;
            end else i++;
        end
    endtask
    task automatic test_reset();
        int bad;
        rst = 1;
        repeat (5) tick();
        rst = 0;
        n_tests++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL reset_txd got %b want 1", TXD); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
        n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        run(100, 0, 0);
        bad = 0;
        for (int t = 0; t < 100; t++) if (line_q[t] !== 1'b1) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL reset_idle_line got %0d low cycles want 0", bad); end
    endtask
    task automatic test_single();
        int bad;
        logic e;
        do_reset();
        wb[0] = 8'h55;
        run(110, 1, 0);
        n_tests++; if (empty_l[1] !== 1'b0) begin n_fail++; $display("FAIL single_empty_lat got %b want 0", empty_l[1]); end
        n_tests++; if (line_q[2] !== 1'b1) begin n_fail++; $display("FAIL single_pre_start got %b want 1", line_q[2]); end
        n_tests++; if (line_q[3] !== 1'b0) begin n_fail++; $display("FAIL single_start_lat got %b want 0", line_q[3]); end
        for (int s = 0; s < 10; s++) begin
            e = (s % 2 == 0) ? 1'b0 : 1'b1;
            bad = 0;
            for (int k = 0; k < 10; k++) if (line_q[3 + 10 * s + k] !== e) bad++;
            n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL single_slot%0d got %0d wrong cycles want 0 (level %b)", s, bad, e); end
        end
        n_tests++; if (busy_l[3] !== 1'b1) begin n_fail++; $display("FAIL single_busy_start got %b want 1", busy_l[3]); end
        n_tests++; if (busy_l[102] !== 1'b1) begin n_fail++; $display("FAIL single_busy_last got %b want 1", busy_l[102]); end
        n_tests++; if (busy_l[103] !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy_l[103]); end
        n_tests++; if (line_q[103] !== 1'b1) begin n_fail++; $display("FAIL single_line_end got %b want 1", line_q[103]); end
    endtask
    task automatic test_back_to_back();
        do_reset();
        wb[0] = 8'hA3;
        wb[1] = 8'h0F;
        run(210, 2, 0);
        decode(210);
        n_tests++; if (rx_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", rx_q.size()); end
        n_tests++; if (rx_q.size() > 0 && rx_q[0] !== 8'hA3) begin n_fail++; $display("FAIL b2b_byte0 got %h want a3", rx_q[0]); end
        n_tests++; if (rx_q.size() > 1 && rx_q[1] !== 8'h0F) begin n_fail++; $display("FAIL b2b_byte1 got %h want 0f", rx_q[1]); end
        n_tests++; if (line_q[103] !== 1'b1) begin n_fail++; $display("FAIL b2b_gap got %b want 1", line_q[103]); end
        n_tests++; if (line_q[104] !== 1'b0) begin n_fail++; $display("FAIL b2b_start2 got %b want 0", line_q[104]); end
        n_tests++; if (empty_l[102] !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_pre got %b want 0", empty_l[102]); end
        n_tests++; if (empty_l[103] !== 1'b1) begin n_fail++; $display("FAIL b2b_empty_post got %b want 1", empty_l[103]); end
    endtask
    task automatic test_overflow();
        int bad;
        do_reset();
        for (int i = 0; i < 18; i++) wb[i] = 8'(i);
        run(1900, 18, 0);
        n_tests++; if (full_l[16] !== 1'b0) begin n_fail++; $display("FAIL ovf_full_early got %b want 0", full_l[16]); end
        n_tests++; if (full_l[17] !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", full_l[17]); end
        decode(1900);
        n_tests++; if (rx_q.size() !== 17) begin n_fail++; $display("FAIL ovf_count got %0d want 17", rx_q.size()); end
        bad = 0;
        foreach (rx_q[i]) if (rx_q[i] !== 8'(i)) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL ovf_order got %0d wrong bytes want 0", bad); end
        n_tests++; if (fe !== 0) begin n_fail++; $display("FAIL ovf_framing got %0d errors want 0", fe); end
    endtask
    task automatic test_wrap();
        int bad, fulls;
        do_reset();
        for (int i = 0; i < 40; i++) wb[i] = 8'(i * 73 + 29);
        run(N, 40, 1);
        decode(N);
        fulls = 0;
        for (int t = 0; t < N; t++) if (full_l[t] === 1'b1) fulls++;
        n_tests++; if (rx_q.size() !== 40) begin n_fail++; $display("FAIL wrap_count got %0d want 40", rx_q.size()); end
        bad = 0;
        foreach (rx_q[i]) if (i < 40 && rx_q[i] !== wb[i]) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_order got %0d wrong bytes want 0", bad); end
        n_tests++; if (fe !== 0) begin n_fail++; $display("FAIL wrap_framing got %0d errors want 0", fe); end
        n_tests++; if (fulls == 0) begin n_fail++; $display("FAIL wrap_full_seen got %0d full cycles want >0", fulls); end
    endtask
    task automatic test_reset_mid();
        int bad;
        do_reset();
        wb[0] = 8'hFF; wb[1] = 8'h01; wb[2] = 8'h02; wb[3] = 8'h03;
        run(58, 4, 0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre got %b want 1", busy); end
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL mid_empty_pre got %b want 0", empty); end
        rst = 1;
        #1;
        n_tests++; if (TXD !== 1'b1) begin n_fail++; $display("FAIL mid_txd_async got %b want 1", TXD); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_async got %b want 0", busy); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty_async got %b want 1", empty); end
        repeat (3) tick();
        rst = 0;
        run(300, 0, 0);
        bad = 0;
        for (int t = 0; t < 300; t++) if (line_q[t] !== 1'b1 || busy_l[t] !== 1'b0 || empty_l[t] !== 1'b1) bad++;
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL mid_after_release got %0d active cycles want 0", bad); end
    endtask
    initial begin
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_t.md
Name: uart_tx_t

Overview:
- Buffered 8N1 UART transmitter: the transmit-direction counterpart of the receive path (uart_rx_t plus fifo).
- Accepts bytes from the fabric through a write strobe into an internal FIFO.
- Serialises each byte onto TXD: start bit, 8 data bits LSB first, one stop bit.
- Sits at the fabric/pin boundary beside uart_rx_t, sharing its clock and baud settings.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 2).
- FIFO_DEPTH, 16, transmit buffer entries; must be a power of 2, >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset.
- data_in  input  8  byte to transmit.
- wr_en  input  1  write strobe; one byte accepted per cycle when not full.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- busy  output  1  a frame is in progress (state != IDLE).
- TXD  output  1  serial line, idle high.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values: TXD=1, busy=0, empty=1, full=0. FIFO pointers, count, bit counter and baud counter are cleared to 0.
- Reset mid-frame aborts the frame immediately: TXD returns to 1 and all buffered data is discarded.
- FIFO:
  - Registered circular buffer of FIFO_DEPTH x 8 with a log2(FIFO_DEPTH)+1-bit count.
  - Write happens when wr_en=1 and full=0.
  - wr_en while full is dropped silently. This holds even if a pop occurs in the same cycle.
  - Simultaneous write and pop while not full: count is unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - full and empty are derived from the registered count and valid in the cycle after the write or pop.
- State machine (registered TXD, no combinational path from inputs to TXD):
  - IDLE:
    - TXD=1.
    - If empty=0: load the shift register from the FIFO head, pop, clear the baud counter, go to START.
  - START:
    - TXD=0 for CLKS_PER_BIT cycles.
    - Then bit index=0 -> DATA.
  - DATA:
    - TXD=shift[0] for CLKS_PER_BIT cycles.
    - Then shift right, bit index+1.
    - After bit index 7 completes -> STOP.
  - STOP:
    - TXD=1 for CLKS_PER_BIT cycles.
    - Then -> IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps; the state advances on the wrap cycle.
- Latency: a byte written into an empty FIFO while in IDLE is visible (empty=0) the next cycle. The pop happens the cycle after that, and TXD falls on the following cycle, i.e. 3 cycles after the wr_en cycle.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames: the STOP->IDLE->START transition inserts exactly one extra idle-high cycle between frames. No other gap is allowed while the FIFO is non-empty.
- busy is 1 from START through the last STOP cycle and 0 in IDLE.
- Writes during transmission never corrupt the in-flight shift register.

Test Plan:
- Reset check: assert rst for 5 cycles, release -> TXD=1, busy=0, empty=1, full=0; no TXD activity for 100 cycles.
- Single byte (CLK_FREQ=1000, BAUD=100, 10 clk/bit), write 0x55:
  - TXD falls 3 cycles after the write.
  - Line sequence per 10-cycle slot: 0,1,0,1,0,1,0,1,0,1 (start, d0..d7, stop).
  - busy deasserts after 100 cycles.
- Back-to-back: write 0xA3, 0x0F on consecutive cycles -> two frames decode to 0xA3 then 0x0F, separated by exactly 1 idle cycle; empty=1 after the second pop.
- Overflow:
  - Hold TXD traffic and write 18 bytes 0x00..0x11 in consecutive cycles (FIFO_DEPTH=16; the first byte pops into the shifter).
  - full asserts; the extra writes are dropped.
  - Received stream is 0x00..0x10 (17 bytes), and 0x11 never appears.
- Wrap-around: stream 40 random bytes with wr_en gated by !full -> serial decode matches the input order exactly; pointers wrap at least twice.
- Reset mid-frame: assert rst during the DATA bit-4 slot of 0xFF with 3 bytes queued -> TXD=1 immediately; after release, empty=1 and no frame is emitted.
